sqrt_seq: RTL

Iterative digit-by-digit (restoring) integer square root engine. It computes one root bit per clock. It sits between the keypressed pulse generator and the display mux, replacing the purely combinational root path with a start/busy/valid handshake. The start input is driven by keypressed enable_out. The radicand comes from the switches. The valid output gates the root onto the seven-segment display; the root is zero-extended to the display width outside this block.

---
 rtl/sqrt_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/sqrt_seq.sv
// Iterative restoring integer square root: one root bit per clock, start/busy/valid handshake.
// root/remainder are registered and change only when an operation completes.
module sqrt_seq #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned N = WIDTH / 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] radicand,
   output logic [N-1:0]     root,
   output logic [N:0]       remainder,
   output logic             busy,
   output logic             valid
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [N+1:0]     rem_q, rem_d;
   logic [N-1:0]     wroot_q, wroot_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     root_q, root_d;
   logic [N:0]       remainder_q, remainder_d;

   // One restoring iteration, all at N+2 bits.
   logic [N+1:0] rem_shift;
   logic [N+1:0] trial;
   logic         take;
   logic [N+1:0] rem_iter;
   logic [N:0]   wroot_ext;
   logic [N-1:0] wroot_iter;

   always_comb begin
      rem_shift  = {rem_q[N-1:0], x_q[WIDTH-1 -: 2]};
      trial      = {wroot_q, 2'b01};
      take       = (rem_shift >= trial);
      rem_iter   = take ? (rem_shift - trial) : rem_shift;
      wroot_ext  = {wroot_q, take};
      wroot_iter = wroot_ext[N-1:0];
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      rem_d       = rem_q;
      wroot_d     = wroot_q;
      cnt_d       = cnt_q;
      root_d      = root_q;
      remainder_d = remainder_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StCalc;
               x_d     = radicand;
               rem_d   = '0;
               wroot_d = '0;
               cnt_d   = CW'(N - 1);
            end
         end
         StCalc: begin
            x_d     = x_q << 2;
            rem_d   = rem_iter;
            wroot_d = wroot_iter;
            if (cnt_q == '0) begin
               state_d     = StDone;
               root_d      = wroot_iter;
               remainder_d = rem_iter[N:0];
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         x_q         <= '0;
         rem_q       <= '0;
         wroot_q     <= '0;
         cnt_q       <= '0;
         root_q      <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         rem_q       <= rem_d;
         wroot_q     <= wroot_d;
         cnt_q       <= cnt_d;
         root_q      <= root_d;
         remainder_q <= remainder_d;
      end
   end

   assign root      = root_q;
   assign remainder = remainder_q;
   assign busy      = (state_q == StCalc);
   assign valid     = (state_q == StDone);

endmodule
